// File: rtl/rftpu_batch_sequencer_v22_if.sv
// Valid/ready source stream carrying one ARRAY_DIM-wide vector per beat.
//   master : producer (drives valid, data; samples ready)
//   slave  : consumer (samples valid, data; drives ready)
interface rftpu_batch_sequencer_v22_if #(
  parameter int WIDTH = 128
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rftpu_batch_sequencer_v22.sv
// Batch sequencer for the rftpu_systolic_v21 core. Runs cfg_num_batches GEMM
// tiles back to back: start pulse, ARRAY_DIM weight rows from wsrc, one
// activation vector from asrc, wait for core_done. Keeps run-level perf
// counters and a watchdog on the WAIT_* states.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_start/cfg_num_batches       run request and batch count
//   cfg_abort                       abort current run
//   wsrc, asrc                      weight-row / activation streams (slave)
//   core_*                          control, data and status toward the core
//   seq_busy/seq_done/seq_error     run status
//   perf_*                          cycles, stalls, batches, MAC ops
module rftpu_batch_sequencer_v22 #(
  parameter int ARRAY_DIM      = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int BATCH_WIDTH    = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int MAC_WIDTH      = 48,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int RW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1,
  localparam int VW = ARRAY_DIM * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic [BATCH_WIDTH-1:0] cfg_num_batches,
  input  logic                   cfg_abort,
  rftpu_batch_sequencer_v22_if.slave wsrc,
  rftpu_batch_sequencer_v22_if.slave asrc,
  output logic                   core_start,
  output logic                   core_weight_load_en,
  output logic [RW-1:0]          core_weight_row_sel,
  output logic [VW-1:0]          core_weight_data,
  output logic [VW-1:0]          core_activation_data,
  input  logic                   core_ready_for_weights,
  input  logic                   core_ready_for_activation,
  input  logic                   core_done,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   seq_error,
  output logic [CNT_WIDTH-1:0]   perf_total_cycles,
  output logic [CNT_WIDTH-1:0]   perf_stall_cycles,
  output logic [BATCH_WIDTH-1:0] perf_batches_done,
  output logic [MAC_WIDTH-1:0]   perf_mac_ops
);
  localparam logic [RW-1:0]        LAST_ROW = RW'(ARRAY_DIM - 1);
  localparam logic [MAC_WIDTH-1:0] MAC_PER_BATCH = MAC_WIDTH'(ARRAY_DIM * ARRAY_DIM * ARRAY_DIM);
  localparam bit                   WD_EN   = TIMEOUT_CYCLES > 0;
  localparam logic [31:0]          WD_LAST = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [2:0] {IDLE, START, WAIT_W, LOAD_W, WAIT_A, ACT, WAIT_D, FIN} state_t;

  state_t                   state;
  logic [BATCH_WIDTH-1:0]   num;
  logic [31:0]              wd;
  logic                     w_hs, a_hs, wait_met, in_wait, wd_fire, stall_now;
  logic [MAC_WIDTH-1:0]     mac_room;

  // Abort must kill strobes and readies in the same cycle, so these are
  // decoded from state and gated by cfg_abort rather than registered.
  assign wsrc.ready          = (state == LOAD_W) && !cfg_abort;
  assign asrc.ready          = (state == ACT) && !cfg_abort;
  assign w_hs                = wsrc.ready && wsrc.valid;
  assign a_hs                = asrc.ready && asrc.valid;
  assign core_weight_load_en = w_hs;
  assign core_weight_data    = wsrc.ready ? wsrc.data : '0;
  assign core_start          = (state == START) && !cfg_abort;
  assign seq_done            = (state == FIN) && !cfg_abort;

  assign in_wait  = (state == WAIT_W) || (state == WAIT_A) || (state == WAIT_D);
  assign wait_met = ((state == WAIT_W) && core_ready_for_weights) ||
                    ((state == WAIT_A) && core_ready_for_activation) ||
                    ((state == WAIT_D) && core_done);
  // A wait that completes on its last allowed cycle is not a timeout.
  assign wd_fire  = WD_EN && in_wait && !wait_met && (wd == WD_LAST);
  assign stall_now = !cfg_abort && (((state == LOAD_W) && !wsrc.valid) ||
                                    ((state == ACT) && !asrc.valid));
  assign mac_room = ~perf_mac_ops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      num                  <= '0;
      wd                   <= '0;
      core_weight_row_sel  <= '0;
      core_activation_data <= '0;
      seq_busy             <= 1'b0;
      seq_error            <= 1'b0;
      perf_total_cycles    <= '0;
      perf_stall_cycles    <= '0;
      perf_batches_done    <= '0;
      perf_mac_ops         <= '0;
    end else begin
      if (seq_busy && !(&perf_total_cycles))
        perf_total_cycles <= perf_total_cycles + 1'b1;
      if (stall_now && !(&perf_stall_cycles))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      wd <= '0;

      if (cfg_abort && state != IDLE) begin
        state    <= IDLE;
        seq_busy <= 1'b0;
      end else if (wd_fire) begin
        seq_error <= 1'b1;
        seq_busy  <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: if (cfg_start && !cfg_abort) begin
            num               <= cfg_num_batches;
            perf_total_cycles <= '0;
            perf_stall_cycles <= '0;
            perf_batches_done <= '0;
            perf_mac_ops      <= '0;
            seq_error         <= 1'b0;
            seq_busy          <= 1'b1;
            state             <= (cfg_num_batches == '0) ? FIN : START;
          end
          START: state <= WAIT_W;
          WAIT_W: if (core_ready_for_weights) begin
            core_weight_row_sel <= '0;
            state               <= LOAD_W;
          end else wd <= wd + 1'b1;
          LOAD_W: if (w_hs) begin
            // Row index holds at the last row once the tile is loaded.
            if (core_weight_row_sel == LAST_ROW) state <= WAIT_A;
            else core_weight_row_sel <= core_weight_row_sel + 1'b1;
          end
          WAIT_A: if (core_ready_for_activation) state <= ACT;
                  else wd <= wd + 1'b1;
          ACT: if (a_hs) begin
            core_activation_data <= asrc.data;
            state                <= WAIT_D;
          end
          WAIT_D: if (core_done) begin
            perf_batches_done <= perf_batches_done + 1'b1;
            perf_mac_ops      <= (mac_room < MAC_PER_BATCH) ? '1 : perf_mac_ops + MAC_PER_BATCH;
            state             <= (perf_batches_done + 1'b1 == num) ? FIN : START;
          end else wd <= wd + 1'b1;
          FIN: begin
            seq_busy <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rftpu_batch_sequencer_v22.sv
module tb_rftpu_batch_sequencer_v22;
  localparam int AD = 16, DW = 8, VW = AD * DW, BW = 16, CW = 32, MW = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [BW-1:0] cfg_num_batches = '0;
  logic          core_start, core_weight_load_en;
  logic [3:0]    core_weight_row_sel;
  logic [VW-1:0] core_weight_data, core_activation_data;
  logic          core_ready_for_weights = 1'b0, core_ready_for_activation = 1'b0, core_done = 1'b0;
  logic          seq_busy, seq_done, seq_error;
  logic [CW-1:0] perf_total_cycles, perf_stall_cycles;
  logic [BW-1:0] perf_batches_done;
  logic [MW-1:0] perf_mac_ops;

  rftpu_batch_sequencer_v22_if #(.WIDTH(VW)) wsrc ();
  rftpu_batch_sequencer_v22_if #(.WIDTH(VW)) asrc ();

  rftpu_batch_sequencer_v22 #(.ARRAY_DIM(AD), .DATA_WIDTH(DW), .BATCH_WIDTH(BW),
    .CNT_WIDTH(CW), .MAC_WIDTH(MW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_num_batches(cfg_num_batches), .cfg_abort(cfg_abort),
    .wsrc(wsrc), .asrc(asrc),
    .core_start(core_start), .core_weight_load_en(core_weight_load_en),
    .core_weight_row_sel(core_weight_row_sel), .core_weight_data(core_weight_data),
    .core_activation_data(core_activation_data),
    .core_ready_for_weights(core_ready_for_weights),
    .core_ready_for_activation(core_ready_for_activation), .core_done(core_done),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_error(seq_error),
    .perf_total_cycles(perf_total_cycles), .perf_stall_cycles(perf_stall_cycles),
    .perf_batches_done(perf_batches_done), .perf_mac_ops(perf_mac_ops));

  // Stimulus knobs (written by the test only)
  int run_id = 0, w_row = 0, w_len = 0, a_len = 0;
  bit no_done = 1'b0;
  // Source/core model and monitor state (written by the model only)
  int seen_id = 0, w_left = 0, a_left = 0, wcnt = 0, acnt = 0, dcnt = 0, exp_row = 0;
  bit ev_start = 0, ev_last = 0, ev_act = 0, act_chk = 0;
  logic [VW-1:0] last_act = '0;
  int n_start = 0, n_beat = 0, n_done = 0, n_act = 0;
  int row_err = 0, data_err = 0, act_err = 0;

  int n_cmp = 0, n_bad = 0;

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Negedge: update source/core inputs from last cycle's events, then
  // (after settling) record this cycle's events.
  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id; w_left = w_len; a_left = a_len;
    end
    if (wsrc.ready && core_weight_row_sel == 4'(w_row) && w_left > 0) begin
      wsrc.valid = 1'b0; w_left--;
    end else wsrc.valid = 1'b1;
    wsrc.data = rnd_vec();
    if (asrc.ready && a_left > 0) begin
      asrc.valid = 1'b0; a_left--;
    end else asrc.valid = 1'b1;
    asrc.data = rnd_vec();

    core_done = 1'b0;
    if (ev_start) begin
      core_ready_for_weights = 1'b0; core_ready_for_activation = 1'b0; wcnt = 1;
    end else if (wcnt > 0) begin
      wcnt--; if (wcnt == 0) core_ready_for_weights = 1'b1;
    end
    if (ev_last) begin
      core_ready_for_activation = 1'b0; acnt = 1;
    end else if (acnt > 0) begin
      acnt--; if (acnt == 0) core_ready_for_activation = 1'b1;
    end
    if (ev_act && !no_done) dcnt = 19;
    else if (dcnt > 0) begin
      dcnt--; if (dcnt == 0) core_done = 1'b1;
    end

    #1;
    ev_start = core_start;
    if (core_start) begin n_start++; exp_row = 0; end
    ev_last = core_weight_load_en && core_weight_row_sel == 4'd15;
    if (core_weight_load_en) begin
      n_beat++;
      if (int'(core_weight_row_sel) != exp_row) row_err++;
      exp_row = (exp_row + 1) % AD;
      if (core_weight_data != wsrc.data) data_err++;
    end
    if (act_chk) begin
      if (core_activation_data != last_act) act_err++;
      act_chk = 1'b0;
    end
    ev_act = asrc.ready && asrc.valid;
    if (ev_act) begin last_act = asrc.data; act_chk = 1'b1; n_act++; end
    if (seq_done) n_done++;
  end

  typedef struct {
    int     num, wrow, wlen, alen;
    int     starts, beats, batches;
    longint mac;
    int     stall, total;
  } vec_t;
  vec_t vecs[6];
  vec_t v1;

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int k = 0; k < max && seq_busy; k++) step();
    chk(name, VW'(seq_busy), '0);
  endtask

  task automatic start_run(input int num, input int wr, input int wl, input int al);
    w_row = wr; w_len = wl; a_len = al; run_id++;
    cfg_num_batches = BW'(num);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s0, b0, d0;
    s0 = n_start; b0 = n_beat; d0 = n_done;
    start_run(v.num, v.wrow, v.wlen, v.alen);
    chk($sformatf("v%0d_err_clr", idx), VW'(seq_error), '0);
    wait_idle($sformatf("v%0d_idle", idx), 3000);
    step();
    chk($sformatf("v%0d_starts", idx), VW'(n_start - s0), VW'(v.starts));
    chk($sformatf("v%0d_beats", idx), VW'(n_beat - b0), VW'(v.beats));
    chk($sformatf("v%0d_dones", idx), VW'(n_done - d0), VW'(1));
    chk($sformatf("v%0d_batches", idx), VW'(perf_batches_done), VW'(v.batches));
    chk($sformatf("v%0d_mac", idx), VW'(perf_mac_ops), VW'(v.mac));
    chk($sformatf("v%0d_stall", idx), VW'(perf_stall_cycles), VW'(v.stall));
    chk($sformatf("v%0d_total", idx), VW'(perf_total_cycles), VW'(v.total));
  endtask

  initial begin
    int s0, d0, a0;
    // One batch = START 1 + WAIT_W 2 + LOAD 16 + WAIT_A 2 + ACT 1 + WAIT_D 20 = 42
    // cycles; a run adds one FIN cycle plus any source stall cycles.
    //            num row len alen starts beats batches mac  stall total
    vecs[0] = '{3,  0,  0,  0,   3,     48,   3,     12288, 0,   127};
    vecs[1] = '{3,  7,  5,  0,   3,     48,   3,     12288, 5,   132};
    vecs[2] = '{0,  0,  0,  0,   0,     0,    0,     0,     0,   1};
    vecs[3] = '{1,  0,  2,  0,   1,     16,   1,     4096,  2,   45};
    vecs[4] = '{2,  15, 3,  0,   2,     32,   2,     8192,  3,   88};
    vecs[5] = '{1,  0,  0,  4,   1,     16,   1,     4096,  4,   47};
    v1      = '{1,  0,  0,  0,   1,     16,   1,     4096,  0,   43};

    step(); step();
    chk("rst_busy", VW'(seq_busy), '0);
    chk("rst_core_start", VW'(core_start), '0);
    chk("rst_total", VW'(perf_total_cycles), '0);
    chk("rst_mac", VW'(perf_mac_ops), '0);
    chk("rst_act_data", core_activation_data, '0);
    chk("rst_w_data", core_weight_data, '0);
    chk("rst_wready", VW'(wsrc.ready), '0);
    rst_n = 1'b1;
    step(); step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Zero-batch run: seq_done in the cycle right after the accepted start.
    s0 = n_start;
    start_run(0, 0, 0, 0);
    chk("zero_done_pulse", VW'(seq_done), VW'(1));
    chk("zero_no_start", VW'(core_start), '0);
    step();
    chk("zero_done_end", VW'(seq_done), '0);
    chk("zero_busy_end", VW'(seq_busy), '0);
    chk("zero_starts", VW'(n_start - s0), '0);

    // Watchdog: core never completes; 64 WAIT_D cycles then error.
    no_done = 1'b1;
    d0 = n_done;
    start_run(1, 0, 0, 0);
    wait_idle("wd_idle", 500);
    chk("wd_error", VW'(seq_error), VW'(1));
    chk("wd_batches", VW'(perf_batches_done), '0);
    chk("wd_no_done", VW'(n_done - d0), '0);
    chk("wd_total", VW'(perf_total_cycles), VW'(86));
    no_done = 1'b0;

    // Abort while loading row 4.
    d0 = n_done;
    start_run(3, 0, 0, 0);
    chk("abort_err_clr", VW'(seq_error), '0);
    for (int k = 0; k < 200 && !(wsrc.ready && core_weight_row_sel == 4'd4); k++) step();
    chk("abort_row", VW'(core_weight_row_sel), VW'(4));
    cfg_abort = 1'b1;
    #1;
    chk("abort_load_en", VW'(core_weight_load_en), '0);
    chk("abort_wready", VW'(wsrc.ready), '0);
    step();
    cfg_abort = 1'b0;
    chk("abort_idle", VW'(seq_busy), '0);
    repeat (5) step();
    chk("abort_no_done", VW'(n_done - d0), '0);
    chk("abort_batches", VW'(perf_batches_done), '0);
    chk("abort_stall", VW'(perf_stall_cycles), '0);
    run_vec(v1, 90);

    // Start together with abort in IDLE is ignored.
    s0 = n_start;
    cfg_num_batches = BW'(2);
    cfg_start = 1'b1; cfg_abort = 1'b1;
    step();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("startabort_busy", VW'(seq_busy), '0);
    repeat (3) step();
    chk("startabort_starts", VW'(n_start - s0), '0);

    // Asynchronous reset in the middle of the second batch's WAIT_D.
    a0 = n_act;
    start_run(2, 0, 0, 0);
    for (int k = 0; k < 300 && n_act < a0 + 2; k++) step();
    chk("rst_mid_reach", VW'(n_act - a0), VW'(2));
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", VW'(seq_busy), '0);
    chk("rst_mid_total", VW'(perf_total_cycles), '0);
    chk("rst_mid_batches", VW'(perf_batches_done), '0);
    chk("rst_mid_mac", VW'(perf_mac_ops), '0);
    chk("rst_mid_act", core_activation_data, '0);
    chk("rst_mid_row", VW'(core_weight_row_sel), '0);
    #1;
    rst_n = 1'b1;
    s0 = n_start;
    repeat (30) step();
    chk("rst_mid_no_start", VW'(n_start - s0), '0);
    chk("rst_mid_idle", VW'(seq_busy), '0);

    chk("row_sequence", VW'(row_err), '0);
    chk("weight_passthru", VW'(data_err), '0);
    chk("act_capture", VW'(act_err), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
